// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the video RAM arbiter
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
//   FETCH_PHASE             : hcnt[1:0] value on which a video fetch is raised
//   state_t                 : arbiter FSM states
//   fetch_addr()            : raster position -> video RAM word address
package vram_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] FETCH_PHASE = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    VID_RD,
    VID_CAP,
    CPU_RD,
    CPU_CAP,
    CPU_WR
  } state_t;

  // One word per 4 pixels: row from vcnt, column from hcnt[7:2].
  // Flip mirrors the screen by inverting both fields.
  function automatic logic [13:0] fetch_addr(input logic [7:0] v,
                                             input logic [5:0] h,
                                             input logic       f);
    return f ? {~v, ~h} : {v, h};
  endfunction

endpackage

// File: rtl/vram_slot_gen.sv
// rtl/vram_slot_gen.sv - video fetch request, address and pending/overrun tracking
//
// Ports:
//   clk_10M, reset          : clock, synchronous active-high reset
//   ce_5M, hcnt, vcnt       : pixel enable and raster counters (hcnt low byte only)
//   h_blank, v_blank, flip  : blanking and screen flip
//   idle                    : arbiter is in IDLE; any outstanding slot is consumed now
//   vid_go                  : a video fetch is wanted this cycle (pending or fresh)
//   vid_addr                : address of that fetch
//   vid_overrun             : sticky, a request arrived while one was still pending
module vram_slot_gen
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_10M,
  input  logic              reset,
  input  logic              ce_5M,
  input  logic [7:0]        hcnt,
  input  logic [7:0]        vcnt,
  input  logic              h_blank,
  input  logic              v_blank,
  input  logic              flip,
  input  logic              idle,
  output logic              vid_go,
  output logic [ADDR_W-1:0] vid_addr,
  output logic              vid_overrun
);

  logic              req;
  logic              pending;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] lat_addr;

  assign req      = ce_5M && (hcnt[1:0] == FETCH_PHASE) && !h_blank && !v_blank;
  assign cur_addr = ADDR_W'(fetch_addr(vcnt, hcnt[7:2], flip));

  // A fresh request seen while IDLE is served straight away so that it
  // wins against a CPU request arriving in the same cycle.
  assign vid_go   = pending || req;
  assign vid_addr = pending ? lat_addr : cur_addr;

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      pending     <= 1'b0;
      lat_addr    <= '0;
      vid_overrun <= 1'b0;
    end else begin
      if (req) begin
        lat_addr <= cur_addr;
      end
      if (idle) begin
        // Pending slot is consumed now; a request in this same cycle is
        // only left over if the consumed one was the older latched slot.
        pending <= pending && req;
      end else if (req) begin
        pending <= 1'b1;
      end
      if (req && pending && !idle) begin
        vid_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares one synchronous video RAM between video fetch and CPU
//
// Ports:
//   clk_10M, reset                       : clock, synchronous active-high reset
//   ce_5M, hcnt, vcnt, h_blank, v_blank,
//   flip                                 : video timing
//   cpu_req, cpu_we, cpu_addr, cpu_wdata : CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack                   : CPU response (ack is a one-cycle pulse)
//   vid_data, vid_valid, vid_overrun     : fetched video word, its strobe, sticky error
//   ram_addr, ram_we, ram_wdata          : registered RAM command
//   ram_rdata                            : RAM data, valid the cycle after the address
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_10M,
  input  logic              reset,
  input  logic              ce_5M,
  input  logic [8:0]        hcnt,
  input  logic [7:0]        vcnt,
  input  logic              h_blank,
  input  logic              v_blank,
  input  logic              flip,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              vid_go;
  logic [ADDR_W-1:0] vid_addr;
  logic              cpu_new;

  // hcnt[8] only distinguishes the blanking region, which arrives decoded.
  logic unused_hcnt8;
  assign unused_hcnt8 = hcnt[8];

  // While cpu_ack is high the CPU is still holding the finished request.
  assign cpu_new = cpu_req && !cpu_ack;

  vram_slot_gen #(
    .ADDR_W(ADDR_W)
  ) u_slot_gen (
    .clk_10M    (clk_10M),
    .reset      (reset),
    .ce_5M      (ce_5M),
    .hcnt       (hcnt[7:0]),
    .vcnt       (vcnt),
    .h_blank    (h_blank),
    .v_blank    (v_blank),
    .flip       (flip),
    .idle       (state == IDLE),
    .vid_go     (vid_go),
    .vid_addr   (vid_addr),
    .vid_overrun(vid_overrun)
  );

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (vid_go) begin
          state_nxt = VID_RD;
        end else if (cpu_new) begin
          state_nxt = cpu_we ? CPU_WR : CPU_RD;
        end
      end
      VID_RD:  state_nxt = VID_CAP;
      VID_CAP: state_nxt = IDLE;
      CPU_RD:  state_nxt = CPU_CAP;
      CPU_CAP: state_nxt = IDLE;
      CPU_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM command is registered on leaving IDLE so it is stable throughout
  // the RD/WR state; CPU inputs are sampled only at that point.
  always_ff @(posedge clk_10M) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      ram_we    <= (state == IDLE) && (state_nxt == CPU_WR);
      vid_valid <= (state == VID_CAP);
      cpu_ack   <= (state == CPU_CAP) || (state == CPU_WR);
      if (state == IDLE) begin
        if (state_nxt == VID_RD) begin
          ram_addr <= vid_addr;
        end else if (state_nxt == CPU_RD) begin
          ram_addr <= cpu_addr;
        end else if (state_nxt == CPU_WR) begin
          ram_addr  <= cpu_addr;
          ram_wdata <= cpu_wdata;
        end
      end
      if (state == VID_CAP) begin
        vid_data <= ram_rdata;
      end
      if (state == CPU_CAP) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

endmodule
